// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between fifo_stream_reader, the FIFO read port and the downstream stream.
// The reader itself uses the master modport; whatever drives it uses the slave modport.
interface fifo_stream_reader_if #(
  parameter int DW   = 16,
  parameter int LENW = 16
) ();
  logic            start;
  logic [LENW-1:0] len;
  logic            busy;
  logic            done;
  logic            err;
  logic            fifo_rd;
  logic [DW-1:0]   fifo_dout;
  logic            fifo_empty;
  logic            fifo_valid;
  logic            fifo_under;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;

  modport master (
    input  start, len, fifo_dout, fifo_empty, fifo_valid, fifo_under, m_ready,
    output busy, done, err, fifo_rd, m_data, m_valid
  );

  modport slave (
    output start, len, fifo_dout, fifo_empty, fifo_valid, fifo_under, m_ready,
    input  busy, done, err, fifo_rd, m_data, m_valid
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains LEN words from a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// state | meaning:  IDLE = waiting for START;  RUN = issuing FIFO reads;  DRAIN = all reads issued, emptying buffer
module fifo_stream_reader #(
  parameter int DW   = 16,
  parameter int LENW = 16
) (
  input  logic clk,
  input  logic rst,
  fifo_stream_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] rd_cnt_q, rd_cnt_d;
  logic [LENW-1:0] out_cnt_q, out_cnt_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      occ_q, occ_d;
  logic [DW-1:0]   buf0_q, buf0_d;
  logic [DW-1:0]   buf1_q, buf1_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic active;
  logic pop;
  logic push;
  logic bad_valid;
  logic credit_ok;
  logic fifo_rd;

  always_comb begin
    active    = (state_q != IDLE);
    pop       = (occ_q != 2'd0) && bus.m_ready;
    // a read is allowed only if the word it returns is guaranteed a buffer slot
    credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});
    fifo_rd   = (state_q == RUN) && !bus.fifo_empty && (rd_cnt_q < len_q) && credit_ok;
    bad_valid = bus.fifo_valid && (!inflight_q || ((occ_q == 2'd2) && !pop));
    push      = active && bus.fifo_valid && !bad_valid && !bus.fifo_under;

    state_d    = state_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    inflight_d = fifo_rd;
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (fifo_rd) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (pop && (out_cnt_q < len_q)) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
    if (active && (bus.fifo_under || bad_valid)) begin
      err_d = 1'b1;
    end

    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = bus.fifo_dout;
        else               buf1_d = bus.fifo_dout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) buf0_d = buf1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = bus.fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.fifo_dout;
        end
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d = 1'b0;
          if (bus.len != '0) begin
            len_d     = bus.len;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (fifo_rd && (rd_cnt_d == len_q)) state_d = DRAIN;
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if (active && pop && (out_cnt_d == len_q)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.fifo_rd = fifo_rd;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.m_data  = buf0_q;
  assign bus.m_valid = (occ_q != 2'd0);

endmodule
